// File: rtl/reg_file_mp_if.sv
// -----------------------------------------------------------------------------
// reg_file_mp_if
// Bundles the read, write, issue and scoreboard signals of the multi-port
// register file so decode/writeback and the register file share one port.
//   master : pipeline side (drives addresses, writes, issue, flush)
//   slave  : register file side (returns read data, busy flags, busy vector)
// Signals:
//   rd_addr  [NRD*AW]   read addresses, port i at [i*AW +: AW]
//   rd_data  [NRD*XLEN] read data, port i at [i*XLEN +: XLEN]
//   rd_busy  [NRD]      source of port i still awaits writeback
//   wr_en    [NWR]      write strobe per write port
//   wr_addr  [NWR*AW]   write target per port
//   wr_data  [NWR*XLEN] write data per port
//   issue_en / issue_addr  mark a destination as pending
//   flush               clear all pending marks
//   busy_vec [NREG]     registered scoreboard state
// -----------------------------------------------------------------------------
interface reg_file_mp_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG),
   parameter int NRD  = 2,
   parameter int NWR  = 1
);
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                issue_en;
   logic [AW-1:0]       issue_addr;
   logic                flush;
   logic [NREG-1:0]     busy_vec;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
      output rd_data, rd_busy, busy_vec
   );
endinterface

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// Parametrised multi-port integer register file with NRD combinational read
// ports, NWR synchronous write ports, same-cycle write-to-read bypass, an
// optional hard-wired zero register and a pending-write scoreboard.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (clears array and scoreboard; while
//        high, read data and busy flags are forced to zero)
//   bus  reg_file_mp_if.slave (read/write/issue/flush/busy signals)
// Interface parameters must match the module parameters.
// -----------------------------------------------------------------------------
module reg_file_mp #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int AW       = $clog2(NREG),
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int ZERO_REG = 1
) (
   input logic          clk,
   input logic          rst,
   reg_file_mp_if.slave bus
);

   logic [XLEN-1:0]     mem_r [NREG];
   logic [NREG-1:0]     busy_r;
   logic [NREG-1:0]     busy_nxt_s;
   logic [NWR-1:0]      wr_ok_s;
   logic                issue_ok_s;
   logic [NRD*XLEN-1:0] rd_data_s;
   logic [NRD-1:0]      rd_busy_s;

   // Qualify write ports and issue: address 0 is inert when it is the zero register.
   always_comb begin
      wr_ok_s    = '0;
      issue_ok_s = 1'b0;
      for (int p = 0; p < NWR; p++) begin
         if ((ZERO_REG != 0) && (bus.wr_addr[p*AW +: AW] == '0)) begin
            wr_ok_s[p] = 1'b0;
         end else begin
            wr_ok_s[p] = bus.wr_en[p];
         end
      end
      if ((ZERO_REG != 0) && (bus.issue_addr == '0)) begin
         issue_ok_s = 1'b0;
      end else begin
         issue_ok_s = bus.issue_en;
      end
   end

   // Next scoreboard: flush, then writeback clears, then issue sets (set wins).
   always_comb begin
      busy_nxt_s = busy_r;
      if (bus.flush) begin
         busy_nxt_s = '0;
      end else begin
         busy_nxt_s = busy_r;
      end
      for (int p = 0; p < NWR; p++) begin
         if (wr_ok_s[p]) begin
            busy_nxt_s[bus.wr_addr[p*AW +: AW]] = 1'b0;
         end else begin
            busy_nxt_s = busy_nxt_s;
         end
      end
      if (issue_ok_s) begin
         busy_nxt_s[bus.issue_addr] = 1'b1;
      end else begin
         busy_nxt_s = busy_nxt_s;
      end
   end

   // Array and scoreboard state; later write ports overwrite earlier ones on collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            mem_r[r] <= '0;
         end
         busy_r <= '0;
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (wr_ok_s[p]) begin
               mem_r[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
            end
         end
         busy_r <= busy_nxt_s;
      end
   end

   // Combinational read: reset, zero register, bypass (highest port), then array.
   always_comb begin
      logic [AW-1:0]   addr_v;
      logic            hit_v;
      logic [XLEN-1:0] byp_v;
      rd_data_s = '0;
      rd_busy_s = '0;
      addr_v    = '0;
      hit_v     = 1'b0;
      byp_v     = '0;
      for (int i = 0; i < NRD; i++) begin
         addr_v = bus.rd_addr[i*AW +: AW];
         hit_v  = 1'b0;
         byp_v  = '0;
         for (int p = 0; p < NWR; p++) begin
            if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] == addr_v)) begin
               hit_v = 1'b1;
               byp_v = bus.wr_data[p*XLEN +: XLEN];
            end else begin
               hit_v = hit_v;
            end
         end
         if (rst) begin
            rd_data_s[i*XLEN +: XLEN] = '0;
            rd_busy_s[i]              = 1'b0;
         end else if ((ZERO_REG != 0) && (addr_v == '0)) begin
            rd_data_s[i*XLEN +: XLEN] = '0;
            rd_busy_s[i]              = 1'b0;
         end else if (hit_v) begin
            rd_data_s[i*XLEN +: XLEN] = byp_v;
            rd_busy_s[i]              = 1'b0;
         end else begin
            rd_data_s[i*XLEN +: XLEN] = mem_r[addr_v];
            rd_busy_s[i]              = busy_r[addr_v];
         end
      end
   end

   assign bus.rd_data  = rd_data_s;
   assign bus.rd_busy  = rd_busy_s;
   assign bus.busy_vec = busy_r;

endmodule

// File: tb/tb_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_reg_file_mp
// Directed testbench for reg_file_mp (XLEN=32, NREG=32, NRD=2, NWR=2,
// ZERO_REG=1). Inputs change 1 time unit after the rising edge; outputs are
// sampled 1 time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_reg_file_mp;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int NRD  = 2;
   localparam int NWR  = 2;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   reg_file_mp_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR)) bus ();

   reg_file_mp #(
      .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Return all pipeline-driven inputs to idle.
   task automatic idle();
      bus.wr_en      = 2'b00;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.issue_en   = 1'b0;
      bus.issue_addr = 5'd0;
      bus.flush      = 1'b0;
   endtask

   task automatic wr0(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      bus.wr_en[0]            = 1'b1;
      bus.wr_addr[0*AW +: AW] = a;
      bus.wr_data[0 +: XLEN]  = d;
   endtask

   task automatic wr1(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      bus.wr_en[1]             = 1'b1;
      bus.wr_addr[1*AW +: AW]  = a;
      bus.wr_data[XLEN +: XLEN] = d;
   endtask

   task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      bus.rd_addr = {a1, a0};
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      idle();
      rd(5'd0, 5'd0);
      tick();
      rst = 1'b0;
      #1;
      check_eq("reset_busy_vec", 64'(bus.busy_vec), 64'h0);
      rd(5'd5, 5'd12);
      #1;
      check_eq("reset_array_x12", 64'(bus.rd_data[XLEN +: XLEN]), 64'h0);

      // Preload x5, then reset with a competing write and issue in the same cycle.
      tick();
      wr0(5'd5, 32'hDEADBEEF);
      tick();
      idle();
      #1;
      check_eq("preload_x5", 64'(bus.rd_data[0 +: XLEN]), 64'hDEADBEEF);
      rst = 1'b1;
      wr1(5'd8, 32'h0000_1111);
      bus.issue_en   = 1'b1;
      bus.issue_addr = 5'd5;
      rd(5'd5, 5'd8);
      #1;
      check_eq("rst_rd_data0", 64'(bus.rd_data[0 +: XLEN]), 64'h0);
      check_eq("rst_rd_data1_bypass_forced", 64'(bus.rd_data[XLEN +: XLEN]), 64'h0);
      check_eq("rst_rd_busy", 64'(bus.rd_busy), 64'h0);
      tick();
      rst = 1'b0;
      idle();
      #1;
      check_eq("post_rst_x5", 64'(bus.rd_data[0 +: XLEN]), 64'h0);
      check_eq("post_rst_x8_write_lost", 64'(bus.rd_data[XLEN +: XLEN]), 64'h0);
      check_eq("post_rst_busy_vec", 64'(bus.busy_vec), 64'h0);

      // Bypass through port 0 seen on read port 1, then from the array.
      wr0(5'd7, 32'h0000_1234);
      rd(5'd0, 5'd7);
      #1;
      check_eq("bypass_x7", 64'(bus.rd_data[XLEN +: XLEN]), 64'h1234);
      tick();
      idle();
      #1;
      check_eq("array_x7", 64'(bus.rd_data[XLEN +: XLEN]), 64'h1234);

      // Zero register ignores writes, bypass included.
      wr0(5'd0, 32'h0000_0055);
      rd(5'd0, 5'd7);
      #1;
      check_eq("x0_bypass_blocked", 64'(bus.rd_data[0 +: XLEN]), 64'h0);
      tick();
      idle();
      #1;
      check_eq("x0_array", 64'(bus.rd_data[0 +: XLEN]), 64'h0);

      // Collision: port 1 wins, both combinationally and in the array.
      wr0(5'd3, 32'h0000_000A);
      wr1(5'd3, 32'h0000_000B);
      rd(5'd3, 5'd7);
      #1;
      check_eq("collide_bypass", 64'(bus.rd_data[0 +: XLEN]), 64'hB);
      tick();
      idle();
      #1;
      check_eq("collide_array", 64'(bus.rd_data[0 +: XLEN]), 64'hB);
      check_eq("collide_other_port", 64'(bus.rd_data[XLEN +: XLEN]), 64'h1234);

      // Scoreboard: issue x9 at t.
      bus.issue_en   = 1'b1;
      bus.issue_addr = 5'd9;
      rd(5'd9, 5'd3);
      #1;
      check_eq("issue_t_not_yet_busy", 64'(bus.busy_vec), 64'h0);
      tick();
      idle();
      #1;
      check_eq("issue_t1_busy_vec", 64'(bus.busy_vec), 64'h0000_0200);
      check_eq("issue_t1_rd_busy", 64'(bus.rd_busy), 64'b01);
      tick();
      #1;
      check_eq("issue_t2_rd_busy", 64'(bus.rd_busy), 64'b01);
      tick();
      wr1(5'd9, 32'h0000_0077);
      #1;
      check_eq("wb_t3_rd_busy", 64'(bus.rd_busy), 64'b00);
      check_eq("wb_t3_rd_data", 64'(bus.rd_data[0 +: XLEN]), 64'h77);
      check_eq("wb_t3_busy_vec", 64'(bus.busy_vec), 64'h0000_0200);
      tick();
      idle();
      #1;
      check_eq("wb_t4_busy_vec", 64'(bus.busy_vec), 64'h0);
      check_eq("wb_t4_rd_data", 64'(bus.rd_data[0 +: XLEN]), 64'h77);

      // Issue/write race on x4: set wins.
      bus.issue_en   = 1'b1;
      bus.issue_addr = 5'd4;
      tick();
      idle();
      #1;
      check_eq("race_pre_busy4", 64'(bus.busy_vec), 64'h0000_0010);
      bus.issue_en   = 1'b1;
      bus.issue_addr = 5'd4;
      wr0(5'd4, 32'h0000_0044);
      rd(5'd4, 5'd9);
      #1;
      check_eq("race_rd_busy_bypass", 64'(bus.rd_busy), 64'b00);
      tick();
      idle();
      #1;
      check_eq("race_busy4_stays", 64'(bus.busy_vec), 64'h0000_0010);
      check_eq("race_rd_busy_after", 64'(bus.rd_busy), 64'b01);
      check_eq("race_x4_data", 64'(bus.rd_data[0 +: XLEN]), 64'h44);

      // Flush with issue x6: only x6 remains pending.
      bus.flush      = 1'b1;
      bus.issue_en   = 1'b1;
      bus.issue_addr = 5'd6;
      tick();
      idle();
      #1;
      check_eq("flush_issue_x6", 64'(bus.busy_vec), 64'h0000_0040);

      // Issue to x0 is ignored; x0 never reports busy.
      bus.issue_en   = 1'b1;
      bus.issue_addr = 5'd0;
      tick();
      idle();
      rd(5'd0, 5'd6);
      #1;
      check_eq("issue_x0_ignored", 64'(bus.busy_vec), 64'h0000_0040);
      check_eq("x0_not_busy_x6_busy", 64'(bus.rd_busy), 64'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
